// File: rtl/rv32_uart_pkg.sv
// Shared constants for the RV32I memory-mapped UART: register offsets,
// status bit positions, FSM encodings and the bit-period calculation.
package rv32_uart_pkg;

    localparam logic UART_REG_DATA   = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_TX_IDLE    = 2;
    localparam int STAT_RX_OVERRUN = 3;
    localparam int STAT_FRAME_ERR  = 4;

    // Encodings shared by the transmit and receive state machines
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Clock cycles per bit, rounded to the nearest integer
    function automatic int bit_cycles(input int clk_freq_mhz, input int baud_rate);
        return (clk_freq_mhz * 1000000 + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; a pop and a push in the
// same cycle are both honoured even when the FIFO is full.
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (LOG2_DEPTH + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv32_uart_fifo.sv
// 8N1 UART peripheral for the RV32I data bus: TX/RX FIFOs, sticky error
// flags and registered read data suited to the core's two-cycle reads.
module rv32_uart_fifo
    import rv32_uart_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_LOG2    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic        tx,
    input  logic        address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ_MHZ, BAUD_RATE);
    localparam int CNT_W      = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

    logic             read_q;
    logic             read_access;
    logic [31:0]      status;
    logic             rx_overrun;
    logic             frame_err;

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]       tx_rdata;
    logic [FIFO_LOG2:0] tx_count;
    logic [1:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_done;

    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]       rx_rdata;
    logic [FIFO_LOG2:0] rx_count;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_s1, rx_s2, rx_s3;
    logic             rx_stop_sample;

    logic             unused_bits;
    assign unused_bits = ^{writedata[31:8], tx_count, rx_count};

    // A held read strobe counts as a single access on its first cycle
    assign read_access = read && !read_q;
    assign tx_push     = write && (address == UART_REG_DATA);
    assign rx_pop      = read_access && (address == UART_REG_DATA);

    uart_sync_fifo #(.WIDTH(8), .LOG2_DEPTH(FIFO_LOG2)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop),
        .wdata(writedata[7:0]), .rdata(tx_rdata), .full(tx_full),
        .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .LOG2_DEPTH(FIFO_LOG2)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
        .wdata(rx_shift), .rdata(rx_rdata), .full(rx_full),
        .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        status                  = '0;
        status[STAT_RX_VALID]   = !rx_empty;
        status[STAT_TX_FULL]    = tx_full;
        status[STAT_TX_IDLE]    = tx_empty && (tx_state == IDLE);
        status[STAT_RX_OVERRUN] = rx_overrun;
        status[STAT_FRAME_ERR]  = frame_err;
    end

    // Bus side: read data register and sticky flags (a set beats a clear)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_q     <= 1'b0;
            readdata   <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            read_q <= read;
            if (read_access)
                readdata <= (address == UART_REG_STATUS) ? status
                          : {24'h0, rx_empty ? 8'h00 : rx_rdata};
            if (rx_push && rx_full && !rx_pop)
                rx_overrun <= 1'b1;
            else if (write && address == UART_REG_STATUS && writedata[STAT_RX_OVERRUN])
                rx_overrun <= 1'b0;
            if (rx_stop_sample && !rx_s2)
                frame_err <= 1'b1;
            else if (write && address == UART_REG_STATUS && writedata[STAT_FRAME_ERR])
                frame_err <= 1'b0;
        end
    end

    // The stop bit can hand straight over to the next start bit
    assign tx_done = (tx_cnt == BIT_LAST);
    assign tx_pop  = !tx_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_done));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= START;
            tx_cnt   <= '0;
            tx_shift <= tx_rdata;
            tx       <= 1'b0;
        end else if (tx_state != IDLE) begin
            if (!tx_done) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    START: begin
                        tx_state <= DATA;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                    DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
                    default: tx_state <= IDLE;
                endcase
            end
        end
    end

    assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == BIT_LAST);
    assign rx_push        = rx_stop_sample && rx_s2;

    // rx_s1/rx_s2 synchronise the line; rx_s3 gives the falling-edge detect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_uart_fifo.sv
// Directed, scoreboard-driven bench for rv32_uart_fifo at 1 MHz / 100 kbaud
// (ten clocks per bit, one hundred per frame).
module tb_rv32_uart_fifo;

    localparam int CLK_MHZ = 1;
    localparam int BAUD    = 100000;
    localparam int BIT     = 10;
    localparam int FRAME   = 10 * BIT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic        address = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       framing_ok;
    } tx_frame_t;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    tx_frame_t  tx_got[$];

    rv32_uart_fifo #(
        .CLK_FREQ_MHZ(CLK_MHZ),
        .BAUD_RATE(BAUD),
        .FIFO_LOG2(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .tx(tx),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: reached cycle %0d, required finish well before", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decodes every frame on tx by sampling at bit centres
    initial begin : tx_monitor
        tx_frame_t f;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                f.start = cycle;
                f.data  = '0;
                repeat (BIT / 2) begin @(posedge clk); #1; end
                f.framing_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) begin @(posedge clk); #1; end
                    f.data[i] = tx;
                end
                repeat (BIT) begin @(posedge clk); #1; end
                f.framing_ok = f.framing_ok && (tx === 1'b1);
                tx_got.push_back(f);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Single-cycle bus write
    task automatic applyStimulus(input logic addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic busRead(input logic addr, input int hold,
                           output logic [31:0] first, output logic [31:0] last);
        address = addr;
        read    = 1'b1;
        tick();
        first = readdata;
        if (hold > 1) tick(hold - 1);
        last = readdata;
        read = 1'b0;
        tick();
    endtask

    task automatic checkStatus(input string tag, input logic [31:0] expected);
        logic [31:0] first, last;
        busRead(1'b1, 1, first, last);
        checkOutput(tag, first, expected);
    endtask

    task automatic checkRxRead(input string tag, input int hold);
        logic [31:0] first, last, expected;
        expected = (rx_exp.size() > 0) ? {24'h0, rx_exp.pop_front()} : 32'h0;
        busRead(1'b0, hold, first, last);
        checkOutput(tag, first, expected);
        if (hold > 1) checkOutput({tag, "_held"}, last, expected);
    endtask

    // Drives one 8N1 frame; optionally issues a one-cycle data read at read_at
    task automatic sendRxFrame(input logic [7:0] data, input logic stop_bit,
                               input int read_at, output logic [31:0] popped);
        int k;
        popped  = '0;
        address = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            k = i / BIT;
            rx   = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : data[k-1];
            read = (i == read_at);
            tick();
            if (i == read_at) popped = readdata;
        end
        read = 1'b0;
        rx   = 1'b1;
    endtask

    task automatic popTxFrame(input string tag, output int start);
        tx_frame_t f;
        logic [7:0] expected;
        int waited = 0;
        start = -1;
        while (tx_got.size() == 0 && waited < 3 * FRAME) begin
            tick();
            waited++;
        end
        checks++;
        assert (tx_got.size() > 0)
        else begin
            errors++;
            $error("[TB] FAIL %s_timeout: observed no frame after %0d cycles, expected one", tag, waited);
        end
        if (tx_got.size() > 0) begin
            f = tx_got.pop_front();
            expected = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
            checkOutput({tag, "_data"}, {24'h0, f.data}, {24'h0, expected});
            checkOutput({tag, "_framing"}, {31'h0, f.framing_ok}, 32'h1);
            start = f.start;
        end
    endtask

    initial begin : stimulus
        logic [31:0] d, dl;
        int          starts[5];
        int          bad, lows, t0, waited;
        logic        exp_bit;
        logic [7:0]  b;

        // Reset
        reset_n = 1'b0;
        tick(3);
        checkOutput("reset_tx", {31'h0, tx}, 32'h1);
        checkOutput("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        checkStatus("reset_status", 32'h4);

        // Single transmit with exact bit timing
        tx_exp.push_back(8'hA5);
        applyStimulus(1'b0, 32'hA5);
        checkOutput("tx_latency_n1", {31'h0, tx}, 32'h1);
        tick();
        checkOutput("tx_latency_n2", {31'h0, tx}, 32'h0);
        b = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            for (int c = 0; c < BIT; c++) begin
                if (tx !== exp_bit) bad++;
                tick();
            end
            checkOutput($sformatf("tx_bit%0d_badcycles", k), bad, 0);
        end
        checkOutput("tx_after_frame", {31'h0, tx}, 32'h1);
        checkStatus("tx_idle_after_frame", 32'h4);
        popTxFrame("tx_single", t0);

        // TX FIFO full: the sixth byte is dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_exp.push_back(8'(i + 1));
            applyStimulus(1'b0, 32'(i + 1));
        end
        checkStatus("tx_full_status", 32'h2);
        for (int i = 0; i < 5; i++) popTxFrame($sformatf("tx_burst%0d", i), starts[i]);
        for (int i = 1; i < 5; i++)
            checkOutput($sformatf("tx_burst_gap%0d", i), starts[i] - starts[i-1], FRAME);
        tick(2 * FRAME);
        checkOutput("tx_no_sixth_byte", tx_got.size(), 0);
        checkStatus("tx_idle_after_burst", 32'h4);

        // Receive and held-read pop
        rx_exp.push_back(8'h3C);
        sendRxFrame(8'h3C, 1'b1, -1, d);
        checkStatus("rx_valid_status", 32'h5);
        checkRxRead("rx_pop_3c", 2);
        checkStatus("rx_empty_status", 32'h4);
        checkRxRead("rx_pop_empty", 1);

        // Overrun after five unread frames
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'h11 * (i + 1));
            if (i < 4) rx_exp.push_back(b);
            sendRxFrame(b, 1'b1, -1, d);
        end
        checkStatus("rx_overrun_status", 32'hD);
        applyStimulus(1'b1, 32'h18);
        checkStatus("rx_overrun_cleared", 32'h5);

        // Pop and push in the same cycle with the FIFO full
        sendRxFrame(8'h77, 1'b1, 97, d);
        checkOutput("rx_same_cycle_pop", d, {24'h0, rx_exp.pop_front()});
        rx_exp.push_back(8'h77);
        checkStatus("rx_same_cycle_no_overrun", 32'h5);

        // Framing error discards the byte
        sendRxFrame(8'h66, 1'b0, -1, d);
        checkStatus("rx_frame_err_status", 32'h15);
        applyStimulus(1'b1, 32'h18);
        checkStatus("rx_flags_cleared", 32'h5);
        checkRxRead("rx_pop_held3", 3);
        checkRxRead("rx_pop_2", 1);
        checkRxRead("rx_pop_3", 1);
        checkRxRead("rx_pop_4", 1);
        checkRxRead("rx_pop_after_drain", 1);
        checkStatus("rx_drained_status", 32'h4);

        // False start glitch
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(FRAME + 20);
        checkStatus("rx_false_start_status", 32'h4);

        // Reset in the middle of a transmit frame with a byte still queued
        mon_en = 1'b0;
        applyStimulus(1'b0, 32'h5A);
        applyStimulus(1'b0, 32'hC3);
        waited = 0;
        while (tx !== 1'b0 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("rst_tx_started", {31'h0, tx}, 32'h0);
        tick(35);
        reset_n = 1'b0;
        tick();
        checkOutput("rst_tx_high", {31'h0, tx}, 32'h1);
        checkOutput("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        checkStatus("rst_tx_fifo_empty", 32'h4);
        lows = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        checkOutput("rst_no_tx_activity", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
